// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and register-read-side handshake bundle for decode_stage.
interface decode_stage_if #(
  parameter int INSTR_W = 30,
  parameter int SREG_W  = 3,
  parameter int VREG_W  = 2,
  parameter int IMM_W   = 24,
  parameter int ADDR_W  = 26
);
  logic in_valid, in_ready, flush, out_valid, out_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [3:0] out_opcode;
  logic [SREG_W-1:0] out_srs1, out_srs2, out_srd;
  logic [VREG_W-1:0] out_vrs1, out_vrd;
  logic out_use_srs1, out_use_srs2, out_use_srd, out_use_vrs1, out_use_vrd;
  logic [IMM_W-1:0] out_imm;
  logic [ADDR_W-1:0] out_addr;
  logic out_jump, out_cond, out_illegal;
  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_opcode, out_srs1, out_srs2, out_srd, out_vrs1, out_vrd,
           out_use_srs1, out_use_srs2, out_use_srd, out_use_vrs1, out_use_vrd,
           out_imm, out_addr, out_jump, out_cond, out_illegal
  );
  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_opcode, out_srs1, out_srs2, out_srd, out_vrs1, out_vrd,
           out_use_srs1, out_use_srs2, out_use_srd, out_use_vrs1, out_use_vrd,
           out_imm, out_addr, out_jump, out_cond, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with a two-entry output/skid buffer and flush.
module decode_stage #(
  parameter int INSTR_W  = 30,
  parameter int SREG_W   = 3,
  parameter int VREG_W   = 2,
  parameter int IMM_W    = 24,
  parameter int ADDR_W   = 26,
  parameter int SIGN_IMM = 0
) (
  input logic clk,
  input logic rst_n,
  decode_stage_if.slave bus
);
  localparam int P  = INSTR_W - 5;
  localparam int IW = INSTR_W - 4 - SREG_W;
  typedef struct packed {
    logic [3:0]        opcode;
    logic [SREG_W-1:0] srs1, srs2, srd;
    logic [VREG_W-1:0] vrs1, vrd;
    logic              use_srs1, use_srs2, use_srd, use_vrs1, use_vrd;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] addr;
    logic              jump, cond, illegal;
  } dec_t;
  dec_t dec, or_q, sr_q;
  logic or_v, sr_v, rdy, acc, drain, fill;
  logic [3:0] op;
  logic [IW-1:0] raw;
  assign op  = bus.in_instr[INSTR_W-1 -: 4];
  assign raw = bus.in_instr[IW-1:0];
  always_comb begin
    dec = '0;
    dec.opcode = op;
    case (op)
      4'b0000, 4'b0110: begin
        dec.srd      = bus.in_instr[P -: SREG_W];
        dec.srs1     = bus.in_instr[P-SREG_W -: SREG_W];
        dec.srs2     = bus.in_instr[P-2*SREG_W -: SREG_W];
        dec.use_srs1 = 1'b1;
        dec.use_srs2 = 1'b1;
        dec.use_srd  = op == 4'b0000;
      end
      4'b0010, 4'b0100, 4'b1010: begin
        dec.srd      = bus.in_instr[P -: SREG_W];
        dec.srs1     = bus.in_instr[P -: SREG_W];
        dec.use_srd  = 1'b1;
        dec.use_srs1 = op != 4'b1010;
        dec.imm      = IMM_W'({{IMM_W{SIGN_IMM != 0 && raw[IW-1]}}, raw});
      end
      4'b0001, 4'b0011, 4'b0101, 4'b1011: begin
        dec.vrd      = bus.in_instr[P -: VREG_W];
        dec.vrs1     = bus.in_instr[P-VREG_W -: VREG_W];
        dec.srs1     = bus.in_instr[P-2*VREG_W -: SREG_W];
        dec.use_vrd  = 1'b1;
        dec.use_srs1 = 1'b1;
        dec.use_vrs1 = op != 4'b0101 && op != 4'b1011;
      end
      4'b1000, 4'b1001: begin
        dec.addr = ADDR_W'(bus.in_instr[P:0]);
        dec.jump = 1'b1;
        dec.cond = op[0];
      end
      4'b0111: ;
      default: dec.illegal = 1'b1;
    endcase
  end
  assign acc   = bus.in_valid && rdy && !bus.flush;
  assign drain = or_v && bus.out_ready;
  // a word accepted while OR holds and does not drain parks in SR
  assign fill  = acc && or_v && !drain;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      or_v <= 1'b0;
      sr_v <= 1'b0;
      rdy  <= 1'b0;
      or_q <= '0;
      sr_q <= '0;
    end else if (bus.flush) begin
      or_v <= 1'b0;
      sr_v <= 1'b0;
      rdy  <= 1'b1;
    end else begin
      if (drain && sr_v) or_q <= sr_q;
      else if (acc && !fill) or_q <= dec;
      if (fill) sr_q <= dec;
      or_v <= sr_v || acc || (or_v && !drain);
      sr_v <= sr_v ? !drain : fill;
      rdy  <= sr_v ? drain : !fill;
    end
  assign bus.in_ready  = rdy;
  assign bus.out_valid = or_v;
  assign {bus.out_opcode, bus.out_srs1, bus.out_srs2, bus.out_srd, bus.out_vrs1, bus.out_vrd,
          bus.out_use_srs1, bus.out_use_srs2, bus.out_use_srd, bus.out_use_vrs1, bus.out_use_vrd,
          bus.out_imm, bus.out_addr, bus.out_jump, bus.out_cond, bus.out_illegal} = or_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus against a queue-based reference of the decode stage.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0, errors = 0, ndrain = 0, idx;
  bit rdy_m, last_acc;
  logic [29:0] q[$];
  logic [29:0] w[3];
  decode_stage_if #(.INSTR_W(30), .SREG_W(3), .VREG_W(2), .IMM_W(24), .ADDR_W(26)) bus();
  decode_stage_if #(.INSTR_W(30), .SREG_W(3), .VREG_W(2), .IMM_W(24), .ADDR_W(26)) bus_s();
  decode_stage #(.SIGN_IMM(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  decode_stage #(.SIGN_IMM(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_instr  = bus.in_instr;
  assign bus_s.flush     = bus.flush;
  assign bus_s.out_ready = bus.out_ready;
  always #5 clk = ~clk;

  function automatic logic [74:0] ref_dec(logic [29:0] x, bit sgn);
    int op = int'(x) / (1 << 26);
    int f = int'(x) % (1 << 26);
    int rd = 0, r1 = 0, r2 = 0, v1 = 0, vd = 0, imm = 0, a = 0;
    bit u1 = 0, u2 = 0, ud = 0, uv1 = 0, uvd = 0, j = 0, c = 0, il = 0;
    if (op == 0 || op == 6) begin
      rd = f / (1 << 23); r1 = f / (1 << 20) % 8; r2 = f / (1 << 17) % 8;
      u1 = 1; u2 = 1; ud = (op == 0);
    end else if (op == 2 || op == 4 || op == 10) begin
      rd = f / (1 << 23); r1 = rd; ud = 1; u1 = (op != 10);
      imm = f % (1 << 23);
      if (sgn && imm >= (1 << 22)) imm += (1 << 24) - (1 << 23);
    end else if (op == 1 || op == 3 || op == 5 || op == 11) begin
      vd = f / (1 << 24); v1 = f / (1 << 22) % 4; r1 = f / (1 << 19) % 8;
      uvd = 1; u1 = 1; uv1 = !(op == 5 || op == 11);
    end else if (op == 8 || op == 9) begin
      a = f; j = 1; c = (op == 9);
    end else il = (op >= 12);
    return {4'(op), 3'(r1), 3'(r2), 3'(rd), 2'(v1), 2'(vd), u1, u2, ud, uv1, uvd, 24'(imm), 26'(a), j, c, il};
  endfunction

  function automatic logic [74:0] obs_of();
    return {bus.out_opcode, bus.out_srs1, bus.out_srs2, bus.out_srd, bus.out_vrs1, bus.out_vrd,
            bus.out_use_srs1, bus.out_use_srs2, bus.out_use_srd, bus.out_use_vrs1, bus.out_use_vrd,
            bus.out_imm, bus.out_addr, bus.out_jump, bus.out_cond, bus.out_illegal};
  endfunction

  task automatic chk(string tag, logic [74:0] got, logic [74:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic cyc();
    logic [74:0] e;
    if (bus.out_valid === 1'b1 && bus.out_ready) ndrain++;
    last_acc = 0;
    if (bus.flush) begin
      q.delete();
      rdy_m = 1;
    end else begin
      if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && rdy_m) begin
        q.push_back(bus.in_instr);
        last_acc = 1;
      end
      rdy_m = q.size() < 2;
    end
    @(posedge clk);
    #1;
    chk("ctl", 75'({bus.out_valid, bus.in_ready}), 75'({q.size() > 0, rdy_m}));
    if (q.size() > 0) begin
      chk("dec", obs_of(), ref_dec(q[0], 0));
      e = ref_dec(q[0], 1);
      chk("imm_sext", 75'(bus_s.out_imm), 75'(e[52:29]));
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.in_valid = 0; bus.in_instr = '0; bus.flush = 0; bus.out_ready = 0;
    rdy_m = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out", obs_of(), '0);
    chk("rst_ctl", 75'({bus.out_valid, bus.in_ready}), '0);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    // directed decodes
    bus.in_valid = 1; bus.out_ready = 1; bus.in_instr = 30'h01DC0000;
    cyc();
    chk("sum", 75'({bus.out_srd, bus.out_srs1, bus.out_srs2, bus.out_use_srs1, bus.out_use_srs2,
                    bus.out_use_srd, bus.out_opcode, bus.out_imm, bus.out_jump}),
        75'({3'd3, 3'd5, 3'd6, 3'b111, 4'd0, 24'd0, 1'b0}));
    bus.in_instr = 30'h117FFFFF;
    cyc();
    chk("subi", 75'({bus.out_srd, bus.out_srs1, bus.out_imm}), 75'({3'd2, 3'd2, 24'h7FFFFF}));
    chk("subi_s", 75'(bus_s.out_imm), 75'(24'hFFFFFF));
    bus.in_instr = 30'h20000ABC;
    cyc();
    chk("j", 75'({bus.out_addr, bus.out_jump, bus.out_cond}), 75'({26'h0000ABC, 2'b10}));
    bus.in_instr = 30'h24000ABC;
    cyc();
    chk("jeq", 75'({bus.out_addr, bus.out_jump, bus.out_cond}), 75'({26'h0000ABC, 2'b11}));
    bus.in_instr = 30'h3FFFFFFF;
    cyc();
    chk("ill", 75'({bus.out_illegal, bus.out_use_srs1, bus.out_use_srs2, bus.out_use_srd,
                    bus.out_use_vrs1, bus.out_use_vrd, bus.out_jump, bus.out_cond}), 75'(8'b1000_0000));
    bus.in_valid = 0;
    cyc();
    // back-pressure: three words, two absorbed, third held upstream
    for (int i = 0; i < 3; i++) w[i] = 30'($urandom);
    idx = 0; ndrain = 0; bus.out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1; bus.in_instr = w[idx < 3 ? idx : 2];
      cyc();
      if (last_acc) idx++;
    end
    chk("stall_rdy", 75'({bus.in_ready, bus.out_valid}), 75'(2'b01));
    bus.out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = idx < 3; bus.in_instr = w[idx < 3 ? idx : 2];
      cyc();
      if (last_acc) idx++;
    end
    chk("stall_cnt", 75'(ndrain), 75'(3));
    // flush with two buffered and one presented
    bus.out_ready = 0; bus.in_valid = 1;
    for (int k = 0; k < 2; k++) begin bus.in_instr = 30'($urandom); cyc(); end
    bus.flush = 1; bus.in_instr = 30'($urandom);
    cyc();
    chk("flush", 75'({bus.out_valid, bus.in_ready}), 75'(2'b01));
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1; ndrain = 0;
    for (int k = 0; k < 3; k++) cyc();
    chk("flush_cnt", 75'(ndrain), '0);
    // asynchronous reset mid-stall
    bus.out_ready = 0; bus.in_valid = 1;
    for (int k = 0; k < 3; k++) begin bus.in_instr = 30'($urandom); cyc(); end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", obs_of(), '0);
    chk("arst_ctl", 75'({bus.out_valid, bus.in_ready}), '0);
    q.delete(); rdy_m = 0; bus.in_valid = 0;
    @(negedge clk) rst_n = 1'b1;
    cyc();
    bus.in_valid = 1; bus.out_ready = 1; bus.in_instr = 30'h117FFFFF;
    cyc();
    chk("post_rst", 75'({bus.out_valid, bus.out_srd, bus.out_imm}), 75'({1'b1, 3'd2, 24'h7FFFFF}));
    // random traffic with held upstream words
    for (int k = 0; k < 400; k++) begin
      if (!(bus.in_valid && !last_acc)) begin
        bus.in_valid = $urandom_range(0, 9) < 7;
        bus.in_instr = 30'($urandom);
      end
      bus.out_ready = $urandom_range(0, 9) < 6;
      bus.flush = $urandom_range(0, 19) == 0;
      cyc();
      if (bus.flush) last_acc = 1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
